// File: rtl/fir_uart_pkg.sv
// Shared types and constants for the FIR output UART stage.
package fir_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int BW_OUT_DEF = 8;
    // Start bit + data bits + stop bit, for the default sample width.
    localparam int FRAME_BITS = BW_OUT_DEF + 2;

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO buffering FIR samples ahead of the serialiser.
// Occupancy is tracked explicitly so full/empty never rely on pointer equality.
module fir_out_fifo
    import fir_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    // A pop on the same edge frees the slot, so full + pop still takes the push.
    assign w_wr  = push & (~full | pop);
    assign w_rd  = pop & ~empty;
    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end

endmodule

// File: rtl/fir_uart_tx.sv
// FIR output serialiser: buffers samples and sends each as an 8N1-style
// frame (start, BW_out data bits LSB first, stop) on a single pin.
module fir_uart_tx
    import fir_uart_pkg::*;
#(
    parameter int BW_out       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int LW  = $clog2(FIFO_DEPTH + 1),
    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1,
    localparam int BWW = (BW_out > 1) ? $clog2(BW_out) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BW_out-1:0] sample_in,
    input  logic              sample_valid,
    output logic              tx,
    output logic              busy,
    output logic              overflow,
    output logic [LW-1:0]     fifo_level
);

    uart_state_t       r_state, w_state_n;
    logic [CW-1:0]     r_cyc, w_cyc_n;
    logic [BWW-1:0]    r_bit, w_bit_n;
    logic [BW_out-1:0] r_shift, w_shift_n, w_shift_dn;
    logic              r_tx, w_tx_n;
    logic              r_busy, w_busy_n;
    logic              r_ovf;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_last_cyc;
    logic [BW_out-1:0] w_rdata;

    fir_out_fifo #(
        .WIDTH (BW_out),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (w_pop),
        .wdata (sample_in),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_last_cyc = (r_cyc == CW'(CLKS_PER_BIT - 1));
    assign w_shift_dn = r_shift >> 1;

    // tx is computed one cycle ahead so the pin comes straight from a flop.
    always_comb begin
        w_state_n = r_state;
        w_cyc_n   = r_cyc;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_busy_n  = r_busy;
        w_pop     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_n   = 1'b1;
                w_busy_n = 1'b0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_rdata;
                    w_state_n = START;
                    w_cyc_n   = '0;
                    w_tx_n    = 1'b0;
                    w_busy_n  = 1'b1;
                end
            end
            START: begin
                w_cyc_n = r_cyc + CW'(1);
                if (w_last_cyc) begin
                    w_state_n = DATA;
                    w_cyc_n   = '0;
                    w_bit_n   = '0;
                    w_tx_n    = r_shift[0];
                end
            end
            DATA: begin
                w_cyc_n = r_cyc + CW'(1);
                if (w_last_cyc) begin
                    w_cyc_n = '0;
                    if (r_bit == BWW'(BW_out - 1)) begin
                        w_state_n = STOP;
                        w_tx_n    = 1'b1;
                    end else begin
                        w_bit_n   = r_bit + BWW'(1);
                        w_shift_n = w_shift_dn;
                        w_tx_n    = w_shift_dn[0];
                    end
                end
            end
            STOP: begin
                w_cyc_n = r_cyc + CW'(1);
                if (w_last_cyc) begin
                    w_cyc_n = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        w_pop     = 1'b1;
                        w_shift_n = w_rdata;
                        w_state_n = START;
                        w_tx_n    = 1'b0;
                    end else begin
                        w_state_n = IDLE;
                        w_tx_n    = 1'b1;
                        w_busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cyc   <= w_cyc_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
            r_ovf   <= r_ovf | (sample_valid & w_full & ~w_pop);
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fir_uart_tx.sv
// Directed bench for fir_uart_tx: reset, framing, back-to-back, overflow,
// full-with-pop and asynchronous mid-frame reset.
module tb_fir_uart_tx;
    import fir_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int FLEN  = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_level;

    int n_tot = 0;
    int n_bad = 0;

    fir_uart_tx #(
        .BW_out       (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs for the next edge, then land 1 time unit after it.
    task automatic cyc(input logic v, input logic [7:0] d);
        sample_valid = v;
        sample_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        sample_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Checks frame positions skip..FLEN-1; leaves the bench on the last stop cycle.
    task automatic chk_frame(input logic [7:0] d, input int skip);
        for (int i = skip; i < FLEN; i++) begin
            int   b;
            logic e;
            b = i / CPB;
            if (b == 0)                   e = 1'b0;
            else if (b == FRAME_BITS - 1) e = 1'b1;
            else                          e = d[b-1];
            chk($sformatf("tx[%02h:%0d]", d, i), tx, e);
            chk($sformatf("busy[%02h:%0d]", d, i), busy, 1);
            if (i < FLEN - 1) cyc(1'b0, 8'h00);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int quiet;
        logic [7:0] s [6];
        s[0] = 8'h3C; s[1] = 8'hC3; s[2] = 8'h0F;
        s[3] = 8'hF0; s[4] = 8'h96; s[5] = 8'h69;

        // reset values held for three cycles
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_lvl", fifo_level, 0);
        end
        reset = 1'b1;

        // single frame
        cyc(1'b1, 8'hA5);
        chk("sf_e0_tx", tx, 1);
        chk("sf_e0_busy", busy, 0);
        chk("sf_e0_lvl", fifo_level, 1);
        cyc(1'b0, 8'h00);
        chk("sf_e1_lvl", fifo_level, 0);
        chk_frame(8'hA5, 0);
        cyc(1'b0, 8'h00);
        chk("sf_end_tx", tx, 1);
        chk("sf_end_busy", busy, 0);

        // back-to-back
        rst();
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h80);
        chk("bb_lvl", fifo_level, 1);
        chk_frame(8'h01, 0);
        cyc(1'b0, 8'h00);
        chk("bb_lvl2", fifo_level, 0);
        chk_frame(8'h80, 0);
        cyc(1'b0, 8'h00);
        chk("bb_end_busy", busy, 0);
        chk("bb_end_tx", tx, 1);

        // overflow: six pushes from idle, sixth dropped
        rst();
        for (int k = 0; k < 5; k++) cyc(1'b1, s[k]);
        chk("of_pre_ovf", overflow, 0);
        chk("of_pre_lvl", fifo_level, 4);
        cyc(1'b1, s[5]);
        chk("of_ovf", overflow, 1);
        chk("of_lvl", fifo_level, 4);
        chk_frame(s[0], 4);
        for (int k = 1; k < 5; k++) begin
            cyc(1'b0, 8'h00);
            chk_frame(s[k], 0);
        end
        cyc(1'b0, 8'h00);
        chk("of_end_busy", busy, 0);
        chk("of_end_lvl", fifo_level, 0);
        chk("of_sticky", overflow, 1);

        // full FIFO with push on the popping stop edge
        rst();
        for (int k = 0; k < 5; k++) cyc(1'b1, s[k]);
        chk("fp_pre_lvl", fifo_level, 4);
        chk_frame(s[0], 3);
        cyc(1'b1, s[5]);
        chk("fp_lvl", fifo_level, 4);
        chk("fp_ovf", overflow, 0);
        for (int k = 1; k < 6; k++) begin
            if (k > 1) cyc(1'b0, 8'h00);
            chk_frame(s[k], 0);
        end
        cyc(1'b0, 8'h00);
        chk("fp_end_busy", busy, 0);
        chk("fp_end_ovf", overflow, 0);

        // asynchronous reset during data bit 3
        rst();
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h5A);
        cyc(1'b1, 8'hFF);
        repeat (15) cyc(1'b0, 8'h00);
        chk("ar_pre_tx", tx, 0);
        chk("ar_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_tx", tx, 1);
        chk("ar_busy", busy, 0);
        chk("ar_lvl", fifo_level, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        quiet = 0;
        for (int k = 0; k < 60; k++) begin
            cyc(1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) quiet++;
        end
        chk("ar_quiet", quiet, 0);
        chk("ar_post_lvl", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
